vme_slave_ctrl: RTL and testbench
=================================

// Module: vme_slave_ctrl
// PURPOSE
//  Cycle sequencer for the A16 VME slave datapath: synchronizes AS*/DS0*/DS1*, latches address/AM/WRITE*,
//  decodes the board window, and strobes the local register file. It drives the DTACK* pad (data + output
//  enable) and the data-buffer enables. Sits between the VME pins and the register decoder/mux/read latch.
// PARAMETERS
//  SYNC_STAGES   2        flops per strobe synchronizer (>=2)
//  ADDR_BASE     16'h7C80 window base, compared on {A[15:1],LWORD}
//  ADDR_MASK     16'hFFC0 window mask (64-byte window)
//  AM_SUP        6'h2D    accepted supervisory A16 AM code
//  AM_USR        6'h29    accepted non-privileged A16 AM code
//  ACK_TIMEOUT   64       max cycles in ACCESS before bus error (only with VME_BERR_TIMEOUT_EN)
// PORTS
//  I_CLK_32M          in   1   system clock, 32 MHz
//  I_VME_SYSRESET_N   in   1   asynchronous reset, active low
//  I_VME_AS           in   1   VME AS*, active low, asynchronous
//  I_VME_DS0          in   1   VME DS0*, active low, asynchronous
//  I_VME_DS1          in   1   VME DS1*, active low, asynchronous
//  I_VME_WR           in   1   VME WRITE*: 1=read, 0=write
//  I_VME_A            in   15  VME A[15:1]
//  I_VME_LWORD        in   1   VME LWORD*
//  I_VME_AM           in   6   VME address modifier
//  O_REG_ADDR         out  16  latched {A[15:1],LWORD} for register decoder/mux
//  O_REG_RD           out  1   1-cycle read strobe to register file
//  O_REG_WR           out  1   1-cycle write strobe to register file
//  I_REG_ACK          in   1   register file done; sampled from cycle after strobe
//  O_LATCH_DOUT       out  1   1-cycle load of read-data output latch
//  O_RD_BUF_EN        out  1   enables board->VME data drivers (active high)
//  O_WR_BUF_EN        out  1   enables VME->board data receivers (active high)
//  O_VME_DTACK_D      out  1   DTACK* pad data (0 = acknowledge)
//  O_VME_DTACK_EN     out  1   DTACK* pad output enable
//  O_VME_BERR         out  1   BERR* request, active high (tied 0 without VME_BERR_TIMEOUT_EN)
//  O_BUSY             out  1   high in any state except IDLE
// BEHAVIOUR
//  - Reset (async, low): state IDLE; sync flops =1; O_REG_ADDR=0; all strobes/enables/BERR/BUSY=0; DTACK_D=1.
//  - All control decisions use synchronized AS/DS only; raw A/AM/WR latched when IDLE sees AS=0 & DS0=0 & DS1=0.
//  - IDLE: on synced AS,DS0,DS1 all low -> latch ADDR/AM/WR -> DECODE. Single-byte cycles (one DS) ignored.
//  - DECODE (1 cyc): hit = AM in {AM_SUP,AM_USR} & (ADDR&MASK)==(BASE&MASK) & LWORD=1.
//    Hit -> ACCESS; miss -> WAIT_AS (no DTACK, no strobe, buffers off).
//  - ACCESS: first cycle pulses O_REG_RD (WR=1) or O_REG_WR (WR=0) exactly once; buffer enable for the
//    direction asserted on entry, held until IDLE. On I_REG_ACK: read -> O_LATCH_DOUT pulse; -> DTACK next cyc.
//  - DTACK: DTACK_EN=1, DTACK_D=0; hold until synced DS0 & DS1 both high -> RELEASE.
//  - RELEASE (1 cyc): DTACK_EN=1, DTACK_D=1 (active rapid release); then EN=0 -> WAIT_AS.
//  - WAIT_AS: wait synced AS high -> IDLE. Back-to-back cycles need AS high >=1 synced cycle.
//  - Latency: ack tied 1 -> DTACK_EN rises 3 cycles after IDLE first sees synced strobes.
//  - Master abort: synced AS high in DECODE/ACCESS/DTACK -> all outputs inactive, IDLE next cycle; no DTACK.
//  - I_REG_ACK outside ACCESS ignored; ack in the strobe cycle itself ignored.
//  - Reset mid-cycle: outputs to reset values immediately; DTACK pad released (EN=0).
// CONFIGURATION
//  VME_BERR_TIMEOUT_EN defined: 7-bit counter cleared on ACCESS entry; at ACK_TIMEOUT cycles without ack,
//  O_VME_BERR=1 (no DTACK) until synced DS0&DS1 high, then WAIT_AS; late ack ignored.
//  Undefined: no counter; ACCESS waits indefinitely; O_VME_BERR constant 0.
// STRUCTURE
//  vme_pkg: state encoding (IDLE,DECODE,ACCESS,DTACK,RELEASE,WAIT_AS), AM_SUP/AM_USR,
//  default ADDR_BASE/ADDR_MASK. Sub-module vme_sync: SYNC_STAGES-deep synchronizer, reset to 1, x3.
// TESTING
//  1 Read 0x7CA0, AM=2D, ack tied 1 -> RD strobe 1 cyc, LATCH_DOUT 1 cyc, DTACK_EN 3 cyc after sync, DTACK_D=0.
//  2 Write 0x7C88, AM=29, ack after 5 cyc -> WR strobe once, WR_BUF_EN=1, DTACK 1 cyc after ack, RD_BUF_EN=0.
//  3 Addr 0x1000 or AM=39 -> no strobe, DTACK_EN stays 0, BUSY drops after AS high.
//  4 DS0&DS1 released during DTACK -> 1 cyc DTACK_D=1 with EN=1, then EN=0; next cycle accepted after AS high.
//  5 AS released in ACCESS, or reset in DTACK -> no/aborted DTACK, all outputs inactive, state IDLE.
//  6 VME_BERR_TIMEOUT_EN, ack never -> BERR=1 at cycle 64 of ACCESS, no DTACK, clears on DS high.

Source files
------------

// File: rtl/vme_pkg.sv
// Shared definitions for the A16 VME slave cycle sequencer: state encoding, accepted AM codes
// and the default board window.
package vme_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StAccess,
    StDtack,
    StRelease,
    StWaitAs,
    StBerr
  } vme_state_e;

  localparam logic [5:0]  AmSup    = 6'h2D;
  localparam logic [5:0]  AmUsr    = 6'h29;
  localparam logic [15:0] AddrBase = 16'h7C80;
  localparam logic [15:0] AddrMask = 16'hFFC0;

  function automatic logic am_accepted(logic [5:0] am, logic [5:0] sup, logic [5:0] usr);
    return (am == sup) || (am == usr);
  endfunction

endpackage

// File: rtl/vme_sync.sv
// Multi-flop synchronizer for one asynchronous active-low VME strobe; resets to the idle level 1.
module vme_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic raw,
  output logic synced
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/vme_slave_ctrl.sv
// A16 VME slave cycle sequencer: strobe sync, window decode, register strobes, DTACK* pad control.
// Define VME_BERR_TIMEOUT_EN to add the ACCESS ack timeout that raises BERR* instead of DTACK*.
module vme_slave_ctrl
  import vme_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] ADDR_BASE   = AddrBase,
  parameter logic [15:0] ADDR_MASK   = AddrMask,
  parameter logic [5:0]  AM_SUP      = AmSup,
  parameter logic [5:0]  AM_USR      = AmUsr
`ifdef VME_BERR_TIMEOUT_EN
  ,
  parameter int unsigned ACK_TIMEOUT = 64
`endif
) (
  input  logic        I_CLK_32M,
  input  logic        I_VME_SYSRESET_N,
  input  logic        I_VME_AS,
  input  logic        I_VME_DS0,
  input  logic        I_VME_DS1,
  input  logic        I_VME_WR,
  input  logic [14:0] I_VME_A,
  input  logic        I_VME_LWORD,
  input  logic [5:0]  I_VME_AM,
  output logic [15:0] O_REG_ADDR,
  output logic        O_REG_RD,
  output logic        O_REG_WR,
  input  logic        I_REG_ACK,
  output logic        O_LATCH_DOUT,
  output logic        O_RD_BUF_EN,
  output logic        O_WR_BUF_EN,
  output logic        O_VME_DTACK_D,
  output logic        O_VME_DTACK_EN,
  output logic        O_VME_BERR,
  output logic        O_BUSY
);

  vme_state_e state_q;
  logic       as_s, ds0_s, ds1_s;
  logic [5:0] am_q;
  logic       rd_q;
  logic       hit;
  logic       strobe_cycle;

  vme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_as  (
    .sysclk(I_CLK_32M), .rst_n(I_VME_SYSRESET_N), .raw(I_VME_AS),  .synced(as_s)
  );
  vme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ds0 (
    .sysclk(I_CLK_32M), .rst_n(I_VME_SYSRESET_N), .raw(I_VME_DS0), .synced(ds0_s)
  );
  vme_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ds1 (
    .sysclk(I_CLK_32M), .rst_n(I_VME_SYSRESET_N), .raw(I_VME_DS1), .synced(ds1_s)
  );

  assign hit = am_accepted(am_q, AM_SUP, AM_USR) &&
               ((O_REG_ADDR & ADDR_MASK) == (ADDR_BASE & ADDR_MASK)) && O_REG_ADDR[0];

  // The first ACCESS cycle carries the strobe; any ack seen there is too early to be real.
  assign strobe_cycle = O_REG_RD | O_REG_WR;

`ifdef VME_BERR_TIMEOUT_EN
  logic       berr_q;
  logic [6:0] cnt_q;
  assign O_VME_BERR = berr_q;
`else
  assign O_VME_BERR = 1'b0;
`endif

  always_ff @(posedge I_CLK_32M or negedge I_VME_SYSRESET_N) begin
    if (!I_VME_SYSRESET_N) begin
      state_q        <= StIdle;
      O_REG_ADDR     <= '0;
      am_q           <= '0;
      rd_q           <= 1'b0;
      O_REG_RD       <= 1'b0;
      O_REG_WR       <= 1'b0;
      O_LATCH_DOUT   <= 1'b0;
      O_RD_BUF_EN    <= 1'b0;
      O_WR_BUF_EN    <= 1'b0;
      O_VME_DTACK_D  <= 1'b1;
      O_VME_DTACK_EN <= 1'b0;
      O_BUSY         <= 1'b0;
`ifdef VME_BERR_TIMEOUT_EN
      berr_q         <= 1'b0;
      cnt_q          <= '0;
`endif
    end else begin
      O_REG_RD     <= 1'b0;
      O_REG_WR     <= 1'b0;
      O_LATCH_DOUT <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!as_s && !ds0_s && !ds1_s) begin
            O_REG_ADDR <= {I_VME_A, I_VME_LWORD};
            am_q       <= I_VME_AM;
            rd_q       <= I_VME_WR;
            O_BUSY     <= 1'b1;
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          if (as_s) begin
            O_BUSY  <= 1'b0;
            state_q <= StIdle;
          end else if (hit) begin
            O_REG_RD    <= rd_q;
            O_REG_WR    <= !rd_q;
            O_RD_BUF_EN <= rd_q;
            O_WR_BUF_EN <= !rd_q;
`ifdef VME_BERR_TIMEOUT_EN
            cnt_q       <= '0;
`endif
            state_q     <= StAccess;
          end else begin
            state_q <= StWaitAs;
          end
        end
        StAccess: begin
          if (as_s) begin
            O_RD_BUF_EN <= 1'b0;
            O_WR_BUF_EN <= 1'b0;
            O_BUSY      <= 1'b0;
            state_q     <= StIdle;
          end else if (!strobe_cycle && I_REG_ACK) begin
            O_LATCH_DOUT   <= rd_q;
            O_VME_DTACK_EN <= 1'b1;
            O_VME_DTACK_D  <= 1'b0;
            state_q        <= StDtack;
`ifdef VME_BERR_TIMEOUT_EN
          end else if (cnt_q == 7'(ACK_TIMEOUT - 1)) begin
            berr_q  <= 1'b1;
            state_q <= StBerr;
          end else begin
            cnt_q <= cnt_q + 7'd1;
`endif
          end
        end
        StDtack: begin
          if (as_s) begin
            O_RD_BUF_EN    <= 1'b0;
            O_WR_BUF_EN    <= 1'b0;
            O_VME_DTACK_EN <= 1'b0;
            O_VME_DTACK_D  <= 1'b1;
            O_BUSY         <= 1'b0;
            state_q        <= StIdle;
          end else if (ds0_s && ds1_s) begin
            // Actively drive DTACK* high for one cycle before tristating.
            O_VME_DTACK_D <= 1'b1;
            state_q       <= StRelease;
          end
        end
        StRelease: begin
          O_VME_DTACK_EN <= 1'b0;
          state_q        <= StWaitAs;
        end
        StWaitAs: begin
          if (as_s) begin
            O_RD_BUF_EN <= 1'b0;
            O_WR_BUF_EN <= 1'b0;
            O_BUSY      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StBerr: begin
`ifdef VME_BERR_TIMEOUT_EN
          if (ds0_s && ds1_s) begin
            berr_q  <= 1'b0;
            state_q <= StWaitAs;
          end
`else
          state_q <= StWaitAs;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_slave_ctrl.sv
// Randomized self-checking bench for vme_slave_ctrl against a transaction-level VME slave model.
module tb_vme_slave_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        as_n = 1'b1, ds0_n = 1'b1, ds1_n = 1'b1, wr_n = 1'b1, lword = 1'b1;
  logic [14:0] vme_a = '0;
  logic [5:0]  vme_am = '0;
  logic        ack = 1'b0;
  logic [15:0] reg_addr;
  logic        reg_rd, reg_wr, latch_dout, rd_buf_en, wr_buf_en;
  logic        dtack_d, dtack_en, berr, busy;

  always #16 clk = ~clk;

  vme_slave_ctrl dut (
    .I_CLK_32M(clk), .I_VME_SYSRESET_N(rst_n), .I_VME_AS(as_n), .I_VME_DS0(ds0_n),
    .I_VME_DS1(ds1_n), .I_VME_WR(wr_n), .I_VME_A(vme_a), .I_VME_LWORD(lword), .I_VME_AM(vme_am),
    .O_REG_ADDR(reg_addr), .O_REG_RD(reg_rd), .O_REG_WR(reg_wr), .I_REG_ACK(ack),
    .O_LATCH_DOUT(latch_dout), .O_RD_BUF_EN(rd_buf_en), .O_WR_BUF_EN(wr_buf_en),
    .O_VME_DTACK_D(dtack_d), .O_VME_DTACK_EN(dtack_en), .O_VME_BERR(berr), .O_BUSY(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-transaction observation record, sampled on the falling edge.
  int cyc = 0;
  bit mon_en = 0;
  int rd_cnt, wr_cnt, latch_cnt, dtack_cnt, rel_cnt, berr_cnt;
  int strobe_cyc, dtack_cyc, busy_cyc, berr_cyc;
  bit rd_buf_seen, wr_buf_seen;

  task automatic mon_clear();
    rd_cnt = 0; wr_cnt = 0; latch_cnt = 0; dtack_cnt = 0; rel_cnt = 0; berr_cnt = 0;
    strobe_cyc = -1; dtack_cyc = -1; busy_cyc = -1; berr_cyc = -1;
    rd_buf_seen = 0; wr_buf_seen = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (reg_rd) begin rd_cnt++; strobe_cyc = cyc; end
      if (reg_wr) begin wr_cnt++; strobe_cyc = cyc; end
      if (latch_dout) latch_cnt++;
      if (dtack_en && !dtack_d) begin dtack_cnt++; if (dtack_cyc < 0) dtack_cyc = cyc; end
      if (dtack_en && dtack_d) rel_cnt++;
      if (berr) begin berr_cnt++; if (berr_cyc < 0) berr_cyc = cyc; end
      if (busy && busy_cyc < 0) busy_cyc = cyc;
      if (rd_buf_en) rd_buf_seen = 1;
      if (wr_buf_en) wr_buf_seen = 1;
    end
  endtask

  task automatic pins_idle();
    as_n = 1; ds0_n = 1; ds1_n = 1;
  endtask

  // One full master cycle. d = 0 ties ack high; d > 0 pulses ack d cycles after the strobe.
  task automatic run_txn(input logic [15:0] a16, input logic lw, input logic [5:0] am,
                         input logic rd, input int d, input bit abort);
    logic [15:0] addr;
    bit          hit;
    int          k;
    addr = {a16[15:1], lw};
    hit  = ((am == 6'h2D) || (am == 6'h29)) && ((addr & 16'hFFC0) == 16'h7C80) && lw;
    mon_clear();
    mon_en = 1;
    ack = (d == 0) && !abort;
    vme_a = a16[15:1]; lword = lw; vme_am = am; wr_n = rd;
    as_n = 0; ds0_n = 0; ds1_n = 0;
    k = 0;
    while (busy_cyc < 0 && k < 10) begin tick(); k++; end
    check_eq("busy_rise", 32'(busy_cyc >= 0), 1);
    check_eq("reg_addr", reg_addr, addr);
    if (!hit) begin
      repeat (3) tick();
      ds0_n = 1; ds1_n = 1;
      tick();
      as_n = 1;
    end else if (abort) begin
      k = 0;
      while (strobe_cyc < 0 && k < 10) begin tick(); k++; end
      repeat ($urandom_range(1, 3)) tick();
      pins_idle();
    end else begin
      k = 0;
      while (dtack_cyc < 0 && k < 40) begin
        tick(); k++;
        if (d > 0 && strobe_cyc >= 0) ack = (cyc == strobe_cyc + d);
      end
      ack = 0;
      check_eq("dtack_seen", 32'(dtack_cyc >= 0), 1);
      check_eq("dtack_latency", dtack_cyc - busy_cyc, 2 + ((d == 0) ? 1 : d));
      repeat ($urandom_range(0, 3)) tick();
      ds0_n = 1; ds1_n = 1;
      k = 0;
      while (dtack_en && k < 10) begin tick(); k++; end
      check_eq("dtack_off", dtack_en, 0);
      as_n = 1;
    end
    k = 0;
    while (busy && k < 10) begin tick(); k++; end
    check_eq("busy_fall", busy, 0);
    tick();
    mon_en = 0;
    ack = 0;
    check_eq("rd_strobes", rd_cnt, 32'(hit && rd));
    check_eq("wr_strobes", wr_cnt, 32'(hit && !rd));
    check_eq("latch_pulses", latch_cnt, 32'(hit && rd && !abort));
    check_eq("dtack_asserted", 32'(dtack_cnt > 0), 32'(hit && !abort));
    check_eq("release_cycles", rel_cnt, 32'(hit && !abort));
    check_eq("rd_buf_seen", rd_buf_seen, 32'(hit && rd));
    check_eq("wr_buf_seen", wr_buf_seen, 32'(hit && !rd));
    check_eq("berr_cycles", berr_cnt, 0);
    check_eq("idle_outputs", {rd_buf_en, wr_buf_en, dtack_en, dtack_d}, 4'b0001);
  endtask

  task automatic reset_in_dtack();
    int k;
    mon_clear();
    mon_en = 1;
    ack = 1;
    vme_a = 15'h3E50; lword = 1; vme_am = 6'h2D; wr_n = 1;
    as_n = 0; ds0_n = 0; ds1_n = 0;
    k = 0;
    while (dtack_cyc < 0 && k < 20) begin tick(); k++; end
    check_eq("rst_dtack_seen", 32'(dtack_cyc >= 0), 1);
    #3 rst_n = 0;
    #1;
    check_eq("rst_outputs",
             {reg_addr, reg_rd, reg_wr, latch_dout, rd_buf_en, wr_buf_en, dtack_en, dtack_d, busy},
             {16'h0000, 8'b0000_0010});
    tick();
    pins_idle();
    ack = 0;
    mon_en = 0;
    tick();
    rst_n = 1;
    repeat (3) tick();
  endtask

`ifdef VME_BERR_TIMEOUT_EN
  task automatic berr_timeout();
    int k;
    mon_clear();
    mon_en = 1;
    ack = 0;
    vme_a = 15'h3E44; lword = 1; vme_am = 6'h29; wr_n = 1;
    as_n = 0; ds0_n = 0; ds1_n = 0;
    k = 0;
    while (berr_cyc < 0 && k < 120) begin tick(); k++; end
    check_eq("berr_latency", berr_cyc - strobe_cyc, 64);
    ack = 1;
    repeat (2) tick();
    ack = 0;
    ds0_n = 1; ds1_n = 1;
    k = 0;
    while (berr && k < 10) begin tick(); k++; end
    check_eq("berr_clear", berr, 0);
    as_n = 1;
    k = 0;
    while (busy && k < 10) begin tick(); k++; end
    tick();
    mon_en = 0;
    check_eq("berr_no_dtack", dtack_cnt + rel_cnt, 0);
    check_eq("berr_busy_fall", busy, 0);
  endtask
`endif

  initial begin
    logic [15:0] a16;
    logic [5:0]  am;
    pins_idle();
    repeat (2) tick();
    check_eq("reset_state",
             {reg_addr, reg_rd, reg_wr, latch_dout, rd_buf_en, wr_buf_en, dtack_en, dtack_d, berr,
              busy},
             {16'h0000, 9'b0_0000_0100});
    rst_n = 1;
    repeat (3) tick();

    run_txn(16'h7CA0, 1'b1, 6'h2D, 1'b1, 0, 1'b0);
    run_txn(16'h7C88, 1'b1, 6'h29, 1'b0, 5, 1'b0);
    run_txn(16'h1000, 1'b1, 6'h2D, 1'b1, 0, 1'b0);
    run_txn(16'h7CA0, 1'b1, 6'h39, 1'b0, 0, 1'b0);
    run_txn(16'h7CA0, 1'b0, 6'h2D, 1'b1, 0, 1'b0);
    run_txn(16'h7CBE, 1'b1, 6'h29, 1'b1, 1, 1'b0);
    run_txn(16'h7CC0, 1'b1, 6'h2D, 1'b1, 0, 1'b0);
    run_txn(16'h7C90, 1'b1, 6'h2D, 1'b1, 0, 1'b1);
    run_txn(16'h7C84, 1'b1, 6'h29, 1'b0, 0, 1'b1);
    reset_in_dtack();
    run_txn(16'h7C80, 1'b1, 6'h2D, 1'b0, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) a16 = 16'h7C80 | 16'($urandom_range(0, 63));
      else a16 = 16'($urandom);
      if ($urandom_range(0, 9) < 6) am = ($urandom_range(0, 1) == 1) ? 6'h2D : 6'h29;
      else am = 6'($urandom);
      run_txn(a16, ($urandom_range(0, 7) != 0), am, 1'($urandom), $urandom_range(0, 6),
              ($urandom_range(0, 6) == 0));
    end

`ifdef VME_BERR_TIMEOUT_EN
    berr_timeout();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
